// File: rtl/mmio_fanout_bridge.sv
// mmio_fanout_bridge: one request port fanned out to num_targets_p MMIO windows.
// Requests strobe the decoded target in the accept cycle; read data returns one
// cycle later and is queued, with write acks, into an in-order response buffer.
// Optional feature macro: MMIO_FANOUT_DECERR_EN (decode-error reporting).
module mmio_fanout_bridge #(
  parameter int data_width_p = 32,
  parameter int addr_width_p = 32,
  parameter int num_targets_p = 4,
  parameter int win_width_p = 12,
  parameter logic [addr_width_p-1:0] base_addr_p = '0,
  parameter int els_p = 3,
  localparam int mask_width_lp = data_width_p / 8
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [data_width_p-1:0]                req_data_i,
  input  logic [addr_width_p-1:0]                req_addr_i,
  input  logic                                   req_v_i,
  input  logic                                   req_w_i,
  input  logic [mask_width_lp-1:0]               req_wmask_i,
  output logic                                   req_ready_and_o,
  output logic [data_width_p-1:0]                resp_data_o,
  output logic                                   resp_v_o,
  input  logic                                   resp_ready_and_i,
  output logic [win_width_p-1:0]                 tgt_addr_o,
  output logic [num_targets_p-1:0]               tgt_write_en_o,
  output logic [num_targets_p-1:0]               tgt_read_en_o,
  output logic [mask_width_lp-1:0]               tgt_wmask_o,
  output logic [data_width_p-1:0]                tgt_wdata_o,
  input  logic [num_targets_p*data_width_p-1:0]  tgt_rdata_i,
  output logic                                   err_o,
  output logic [addr_width_p-1:0]                err_addr_o
);

  localparam int HiW  = addr_width_p - win_width_p;
  localparam int SelW = (num_targets_p > 1) ? $clog2(num_targets_p) : 1;
  localparam int LgM  = $clog2(mask_width_lp);
  localparam int PtrW = $clog2(els_p);
  localparam int CntW = $clog2(els_p + 1);
  localparam logic [HiW-1:0] BaseHi = base_addr_p[addr_width_p-1:win_width_p];

  logic [HiW-1:0]          w_hi;
  logic [HiW-1:0]          w_idx;
  logic                    w_mapped;
  logic                    w_acc;
  logic                    w_deq;
  logic [LgM-1:0]          w_sh;
  logic [data_width_p-1:0] w_rdata_p0;
  logic [data_width_p-1:0] w_resp_p0;

  logic [CntW-1:0]         r_count;
  logic                    r_vld_p0;
  logic                    r_rd_p0;
  logic                    r_map_p0;
  logic [SelW-1:0]         r_sel_p0;
  logic [data_width_p-1:0] r_mem [els_p];
  logic [PtrW-1:0]         r_wptr;
  logic [PtrW-1:0]         r_rptr;

  // Byte-lane shift for narrow writes: size is implied by the strobe pattern.
  function automatic logic [LgM-1:0] lane_shift(input logic [mask_width_lp-1:0] m,
                                                input logic [LgM-1:0] off);
    logic [LgM-1:0] sh;
    sh = '0;
    if (m == mask_width_lp'(1))
      sh = off;
    else if (m == mask_width_lp'(3))
      sh = off & ~LgM'(1);
    else if ((data_width_p == 64) && (m == mask_width_lp'('hF)))
      sh = off & ~LgM'(3);
    return sh;
  endfunction

  // Lane-aligned byte mask; unrecognised strobe patterns become a full-word write.
  function automatic logic [mask_width_lp-1:0] lane_mask(input logic [mask_width_lp-1:0] m,
                                                         input logic [LgM-1:0] sh);
    logic [mask_width_lp-1:0] lm;
    lm = '1;
    if ((m == mask_width_lp'(1)) || (m == mask_width_lp'(3)) ||
        ((data_width_p == 64) && (m == mask_width_lp'('hF))))
      lm = m << sh;
    return lm;
  endfunction

  assign w_hi     = req_addr_i[addr_width_p-1:win_width_p];
  assign w_idx    = w_hi - BaseHi;
  assign w_mapped = (w_hi >= BaseHi) && ({1'b0, w_idx} < (HiW+1)'(num_targets_p));

  // Ready depends only on registered occupancy, never on resp_ready_and_i.
  assign req_ready_and_o = !reset_i && (r_count < CntW'(els_p));
  assign w_acc           = req_v_i && req_ready_and_o;
  // Occupancy counts the in-flight stage too, so the buffer is empty when only it remains.
  assign resp_v_o        = !reset_i && (r_count != {{(CntW-1){1'b0}}, r_vld_p0});
  assign w_deq           = resp_v_o && resp_ready_and_i;
  assign resp_data_o     = r_mem[r_rptr];
  assign tgt_addr_o      = req_addr_i[win_width_p-1:0];

  // Decode and lane steering for the request presented this cycle.
  always_comb begin
    tgt_write_en_o = '0;
    tgt_read_en_o  = '0;
    w_sh           = lane_shift(req_wmask_i, req_addr_i[LgM-1:0]);
    tgt_wmask_o    = lane_mask(req_wmask_i, w_sh);
    tgt_wdata_o    = req_data_i << {w_sh, 3'b000};
    for (int k = 0; k < num_targets_p; k++) begin
      if (w_acc && w_mapped && (w_idx == HiW'(k))) begin
        if (req_w_i) tgt_write_en_o[k] = 1'b1;
        else         tgt_read_en_o[k]  = 1'b1;
      end
    end
  end

  // Stage p0 -> buffer: select returning target data and form the response word.
  always_comb begin
    w_rdata_p0 = '0;
    for (int k = 0; k < num_targets_p; k++)
      if (r_sel_p0 == SelW'(k)) w_rdata_p0 = tgt_rdata_i[k*data_width_p +: data_width_p];
    if (!r_rd_p0)
      w_resp_p0 = '0;
    else if (r_map_p0)
      w_resp_p0 = w_rdata_p0;
    else
`ifdef MMIO_FANOUT_DECERR_EN
      w_resp_p0 = {(data_width_p/32){32'hDEADBEEF}};
`else
      w_resp_p0 = '0;
`endif
  end

  // Control state: stage valid, occupancy counter and buffer pointers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_vld_p0 <= 1'b0;
      r_count  <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
    end else begin
      r_vld_p0 <= w_acc;
      if (w_acc && !w_deq)
        r_count <= r_count + 1'b1;
      else if (!w_acc && w_deq)
        r_count <= r_count - 1'b1;
      if (r_vld_p0)
        r_wptr <= (r_wptr == PtrW'(els_p-1)) ? '0 : r_wptr + 1'b1;
      if (w_deq)
        r_rptr <= (r_rptr == PtrW'(els_p-1)) ? '0 : r_rptr + 1'b1;
    end
  end

  // Datapath: accept -> p0 request attributes, p0 -> buffer entry.
  always_ff @(posedge clk_i) begin
    if (w_acc) begin
      r_rd_p0  <= !req_w_i;
      r_map_p0 <= w_mapped;
      r_sel_p0 <= w_idx[SelW-1:0];
    end
    if (r_vld_p0)
      r_mem[r_wptr] <= w_resp_p0;
  end

`ifdef MMIO_FANOUT_DECERR_EN
  logic                    r_err;
  logic [addr_width_p-1:0] r_err_addr;

  // Sticky decode error; only the first unmapped address is kept.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else if (w_acc && !w_mapped && !r_err) begin
      r_err      <= 1'b1;
      r_err_addr <= req_addr_i;
    end
  end

  assign err_o      = r_err && !reset_i;
  assign err_addr_o = reset_i ? '0 : r_err_addr;
`else
  assign err_o      = 1'b0;
  assign err_addr_o = '0;
`endif

endmodule

// File: doc/mmio_fanout_bridge.md
MMIO_FANOUT_BRIDGE -- requirements
Module: mmio_fanout_bridge

Interface
REQ-001 SHALL have parameter data_width_p, default 32, meaning request/response data width; legal values are 32 or 64.
REQ-002 SHALL have parameter addr_width_p, default 32, meaning request address width.
REQ-003 SHALL have parameter num_targets_p, default 4, meaning number of MMIO targets; legal range is 1..8.
REQ-004 SHALL have parameter win_width_p, default 12, meaning log2 of the byte size of each target window.
REQ-005 SHALL have parameter base_addr_p, default 0, meaning the address of the window for target 0; it SHALL be aligned to 2^win_width_p.
REQ-006 SHALL have parameter els_p, default 3, meaning the maximum number of outstanding requests; els_p SHALL be at least 2.
REQ-007 SHALL use mask_width_lp = data_width_p/8.
REQ-008 SHALL have the following ports:
- clk_i  in  1  sole clock
- reset_i  in  1  synchronous reset, active-high
- req_data_i  in  data_width_p  write data, low-justified for narrow writes
- req_addr_i  in  addr_width_p  byte address
- req_v_i  in  1  request valid
- req_w_i  in  1  1 = write, 0 = read
- req_wmask_i  in  mask_width_lp  low-justified byte strobes
- req_ready_and_o  out  1  request ready
- resp_data_o  out  data_width_p  response data
- resp_v_o  out  1  response valid
- resp_ready_and_i  in  1  response ready
- tgt_addr_o  out  win_width_p  window offset, equal to req_addr_i[win_width_p-1:0]
- tgt_write_en_o  out  num_targets_p  one-hot write strobe
- tgt_read_en_o  out  num_targets_p  one-hot read strobe
- tgt_wmask_o  out  mask_width_lp  lane-aligned byte mask
- tgt_wdata_o  out  data_width_p  lane-aligned write data
- tgt_rdata_i  in  num_targets_p*data_width_p  synchronous read data, valid the cycle after the read strobe
- err_o  out  1  sticky decode error
- err_addr_o  out  addr_width_p  address of the first decode error

Function
REQ-009 SHALL accept a request in any cycle in which req_v_i and req_ready_and_o are both high.
REQ-010 SHALL decode target k when req_addr_i[addr_width_p-1:win_width_p] equals (base_addr_p>>win_width_p)+k, for k < num_targets_p.
REQ-011 SHALL assert exactly one bit of tgt_write_en_o or tgt_read_en_o, combinationally, in the acceptance cycle of a mapped request, and SHALL assert no bits in any other cycle.
REQ-012 SHALL generate tgt_wmask_o from req_wmask_i using the byte offset of req_addr_i, as follows:
- 'h1 SHALL shift left by addr[lg(mask_width_lp)-1:0].
- 'h3 SHALL shift left by the address aligned down to 2.
- 'hF SHALL shift left by the address aligned down to 4 (this applies only when data_width_p is 64).
- Any other value SHALL produce an all-ones mask.
REQ-013 SHALL shift req_data_i by the same byte offset as the mask to produce tgt_wdata_o.
REQ-014 SHALL produce exactly one response per accepted request, and responses SHALL be returned in acceptance order.
REQ-015 SHALL capture tgt_rdata_i of the selected target at the end of cycle N+1 for a read accepted in cycle N, and SHALL present that response on resp_v_o no earlier than cycle N+2; when the response buffer is empty, it SHALL appear in exactly cycle N+2.
REQ-016 SHALL return a write response with resp_data_o equal to 0.
REQ-017 SHALL hold resp_data_o stable while resp_v_o is high and resp_ready_and_i is low.
REQ-018 SHALL maintain an outstanding counter covering requests accepted but not yet dequeued, with req_ready_and_o = (count < els_p), and SHALL have no combinational path from resp_ready_and_i to req_ready_and_o.
REQ-019 SHALL leave the counter unchanged on a simultaneous accept and dequeue.
REQ-020 SHALL size the response buffer at els_p entries with wrap-around read and write pointers; the buffer SHALL never overflow.
REQ-021 SHALL sustain one request per cycle when els_p >= 3 and resp_ready_and_i is held high; with els_p = 2, it SHALL sustain 2 requests per 3 cycles.

Reset
REQ-022 SHALL, while reset_i is high, drive req_ready_and_o, resp_v_o, all tgt enables and err_o to 0, and err_addr_o to 0.
REQ-023 SHALL, when reset is applied mid-operation, discard all in-flight and buffered responses; no response SHALL emerge after reset.

Configuration
REQ-024 SHALL, with MMIO_FANOUT_DECERR_EN defined, handle an unmapped request as follows:
- Read response data SHALL be 'hDEADBEEF, replicated to data_width_p.
- err_o SHALL set the cycle after acceptance and remain set until reset.
- err_addr_o SHALL capture the first unmapped address only.
REQ-025 SHALL, without MMIO_FANOUT_DECERR_EN, respond to an unmapped read with 0, tie err_o to 0, and tie err_addr_o to 0.
REQ-026 SHALL, in both configurations, strobe no target for an unmapped request and still return one response for it.

Verification
REQ-027 Bench SHALL cover: read of target 2 at base+0x2004 with tgt_rdata_i[2]='h1234 -> tgt_read_en_o='b0100 in cycle N, tgt_addr_o='h004, resp 'h1234 with resp_v_o high in cycle N+2.
REQ-028 Bench SHALL cover: byte write of data 'hAB with mask 'h1 at offset 3 (32-bit configuration) -> tgt_wmask_o='b1000, tgt_wdata_o='hAB000000, response data 0.
REQ-029 Bench SHALL cover: 10 back-to-back reads with els_p=3 and resp_ready_and_i high -> 10 in-order responses in 10 consecutive cycles.
REQ-030 Bench SHALL cover: resp_ready_and_i low, 4 requests offered with els_p=3 -> req_ready_and_o low after the 3rd acceptance, no loss, order kept once ready rises.
REQ-031 Bench SHALL cover: read of base+4*2^win_width_p with num_targets_p=4 -> no strobe; resp 'hDEADBEEF and err_o=1 with the macro defined, resp 0 and err_o=0 without it.
REQ-032 Bench SHALL cover: reset asserted with 2 requests outstanding -> resp_v_o=0 and no responses after reset deasserts.
